// File: rtl/ssp_pkg.sv
// ssp_pkg: shared SSP widths, FIFO sizing constants and serializer state type.
package ssp_pkg;
    localparam int SSP_WIDTH = 8;
    localparam int SSP_DEPTH = 4;
    localparam int SSP_PTR_W = $clog2(SSP_DEPTH);
    localparam int SSP_CNT_W = $clog2(SSP_DEPTH + 1);
    typedef enum logic [1:0] {IDLE, SYNC, SHIFT} ssp_state_e;
endpackage

// File: rtl/ssp_tx_fifo.sv
// ssp_tx_fifo: byte FIFO with wrapping pointers, registered count and full/empty flags.
module ssp_tx_fifo
    import ssp_pkg::*;
#(
    parameter int WIDTH = SSP_WIDTH,
    parameter int DEPTH = SSP_DEPTH
) (
    input  logic             pclk,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic wr, rd;
    // full is taken from the pre-edge count, so a push alongside a pop from full is dropped
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign rdata = mem[rptr];
    always_ff @(posedge pclk) begin
        if (wr) mem[wptr] <= wdata;
        if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            if (wr && !rd) count <= count + 1'b1;
            else if (rd && !wr) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/ssp_tx_port.sv
// ssp_tx_port: APB write port into a byte FIFO, drained MSB-first as TI-style SSP frames.
module ssp_tx_port
    import ssp_pkg::*;
#(
    parameter int WIDTH = SSP_WIDTH,
    parameter int DEPTH = SSP_DEPTH
) (
    input  logic             pclk,
    input  logic             clr,
    input  logic             psel,
    input  logic             pwrite,
    input  logic [WIDTH-1:0] pwdata,
    output logic             ssptxintr,
    output logic             tx_empty,
    output logic             tx_busy,
    output logic             sspclkout,
    output logic             sspfssout,
    output logic             ssptxd
);
    localparam logic [2:0] LAST = 3'(WIDTH - 1);
    ssp_state_e state, state_n;
    logic [2:0] bitcnt, bitcnt_n;
    logic [WIDTH-1:0] shift, shift_n, rdata;
    logic ph, fss_n, txd_n, pop;
    ssp_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .pclk(pclk), .clr(clr), .push(psel && pwrite), .pop(pop),
        .wdata(pwdata), .rdata(rdata), .full(ssptxintr), .empty(tx_empty)
    );
    assign sspclkout = ph;
    assign tx_busy   = state != IDLE;
    always_ff @(posedge pclk) begin
        if (clr) begin
            ph        <= 1'b0;
            state     <= IDLE;
            bitcnt    <= '0;
            shift     <= '0;
            sspfssout <= 1'b0;
            ssptxd    <= 1'b0;
        end else begin
            ph        <= !ph;
            state     <= state_n;
            bitcnt    <= bitcnt_n;
            shift     <= shift_n;
            sspfssout <= fss_n;
            ssptxd    <= txd_n;
        end
    end
    // the serializer only advances on boundary edges, where ph rises
    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        shift_n  = shift;
        fss_n    = sspfssout;
        txd_n    = ssptxd;
        pop      = 1'b0;
        if (!ph) begin
            case (state)
                IDLE: begin
                    fss_n = !tx_empty;
                    txd_n = 1'b0;
                    if (!tx_empty) begin
                        pop     = 1'b1;
                        shift_n = rdata;
                        state_n = SYNC;
                    end
                end
                SYNC: begin
                    fss_n    = 1'b0;
                    txd_n    = shift[WIDTH-1];
                    bitcnt_n = LAST;
                    state_n  = SHIFT;
                end
                SHIFT: begin
                    if (bitcnt != '0) begin
                        shift_n  = {shift[WIDTH-2:0], 1'b0};
                        txd_n    = shift[WIDTH-2];
                        bitcnt_n = bitcnt - 1'b1;
                    end else if (!tx_empty) begin
                        pop     = 1'b1;
                        shift_n = rdata;
                        fss_n   = 1'b1;
                        state_n = SYNC;
                    end else begin
                        txd_n   = 1'b0;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: doc/ssp_tx_port.md
# ssp_tx_port

Transmit half of the SSP: an APB-side write port feeding a 4-deep byte FIFO, plus a serializer that drives TI-style synchronous-serial frames on SSPCLKOUT, SSPFSSOUT and SSPTXD. It sits opposite the receive FIFO path. The CPU pushes bytes with psel/pwrite, and the block drains them MSB-first, one frame per byte, back-to-back while data remains.

## Interface
- WIDTH, 8, data word width in bits
- DEPTH, 4, FIFO entries; power of two
- pclk  in  1  system clock; all logic on its rising edge
- clr  in  1  reset, synchronous, active-high
- psel  in  1  peripheral select
- pwrite  in  1  write strobe; push when psel && pwrite
- pwdata  in  WIDTH  byte to transmit
- ssptxintr  out  1  FIFO full flag; writes are dropped while high
- tx_empty  out  1  FIFO empty flag
- tx_busy  out  1  frame in progress (SYNC or SHIFT state)
- sspclkout  out  1  serial clock, pclk/2
- sspfssout  out  1  frame sync, one serial cycle ahead of the MSB
- ssptxd  out  1  serial data, MSB first

## Operation
- FIFO:
  - Registered count 0..DEPTH, with wrapping log2(DEPTH)-bit read and write pointers.
  - ssptxintr = (count==DEPTH). tx_empty = (count==0).
- Push: on an edge with psel && pwrite && !ssptxintr, pwdata is written at wptr, wptr increments, and count increments.
  - A push while full is ignored: no pointer or count change, and no error output.
- Pop: done only by the serializer, and only when count>0.
  - Push and pop on the same edge leave count unchanged and move both pointers.
  - Full is evaluated on the pre-edge count, so a push on the same edge as a pop from a full FIFO is still dropped.
- Serial clock: internal phase bit ph toggles every pclk and drives sspclkout directly.
  - A "boundary edge" is a pclk edge where ph goes 0->1.
  - The serializer acts only on boundary edges, so each serial cycle is 2 pclk.
- FSM states: IDLE, SYNC, SHIFT. It also holds a 3-bit bit counter and a WIDTH-bit shift register.
  - IDLE: at a boundary edge with count>0, pop into the shift register, set sspfssout=1, go to SYNC. Otherwise stay, with sspfssout=0 and ssptxd=0.
  - SYNC: at the next boundary edge, set sspfssout=0, ssptxd=shift[WIDTH-1], bitcnt=WIDTH-1, go to SHIFT.
  - SHIFT: at each boundary edge with bitcnt>0, shift left, drive the next bit, and decrement bitcnt.
  - SHIFT, at the boundary edge with bitcnt==0:
    - If count>0: pop, set sspfssout=1, go to SYNC. There is no idle gap.
    - Otherwise: ssptxd=0, go to IDLE.
- tx_busy = (state != IDLE).

## Timing
- Reset: clr high at an edge sets the following:
  - count=0 and pointers=0
  - state=IDLE and ph=0
  - sspclkout=0, sspfssout=0, ssptxd=0, tx_busy=0, ssptxintr=0, tx_empty=1
- Reset mid-frame aborts the frame. There is no partial-byte completion.
- Push to visible flag: 1 pclk. ssptxintr and tx_empty are registered.
- Write to frame start: a byte pushed at edge t into an idle, empty block pops at the first boundary edge after t, which is 1 or 2 pclk later.
- Frame length: 1 sync cycle plus WIDTH data cycles, i.e. 9 serial cycles = 18 pclk.
  - Back-to-back frames repeat every 18 pclk.
- All serial outputs change only on boundary edges, i.e. the sspclkout rising edge. The far end samples on the falling edge.

## Structure
- Shared package ssp_pkg holds:
  - WIDTH and DEPTH defaults
  - the state enum (IDLE, SYNC, SHIFT)
  - the pointer and count width constants, which are also used by the receive side
- Sub-module ssp_tx_fifo contains the storage, pointers, count and flags. It has a push/pop interface and is the mirror of the receive FIFO.
- The top level holds ph, the FSM, bitcnt and the shift register.

## Test plan
- Reset: assert clr for 2 edges, then release. Required: every output is 0 except tx_empty=1, and sspclkout toggles every pclk starting from 0.
- Single byte: push 0xA2.
  - tx_empty falls after 1 pclk.
  - sspfssout is high for 2 pclk, then ssptxd carries 1,0,1,0,0,0,1,0, each held 2 pclk.
  - Then tx_busy=0 and ssptxd=0.
- Fill and drop: push 0xC3, 0xFF, 0xCC, 0xBB on consecutive edges before the first boundary, then push 0x12.
  - ssptxintr=1 after the fourth push.
  - 0x12 is dropped.
  - Output is 4 frames C3, FF, CC, BB, with sspfssout pulsing every 18 pclk and no gap.
- Refill during transmission: while the FIFO is full, push 0x37 on the edge a pop occurs. It is dropped. A push 1 pclk later is accepted and transmitted fifth.
- Reset mid-frame: assert clr during bit 4 of 0x5A with 2 bytes queued. Required:
  - outputs are 0 on the next edge
  - FIFO is empty
  - no further frames are sent
  - a new push of 0x81 transmits correctly afterwards.
